// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable, glitch-free clock divider.
// Makes clk_out (period 2*cur_div) plus a one-cycle clk_rise strobe.
//
// Ports:
//   clk, rst      system clock, async active-high reset
//   run           level, 1 = produce clk_out, 0 = stop in low phase
//   cfg_req       one-cycle pulse, load cfg_div as new half-period
//   cfg_div       requested half-period, sampled with cfg_req
//   cfg_ack       one-cycle pulse, request applied or rejected
//   cfg_err       pulses with cfg_ack when cfg_div==0 was rejected
//   cfg_busy      accepted request waiting for a falling toggle
//   cur_div       half-period in effect
//   running       high in RUN or STOP
//   clk_out       divided clock, 50% duty
//   clk_rise      high for the cycle after clk_out goes 0->1
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             cfg_req,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic             cfg_busy,
   output logic [CNT_W-1:0] cur_div,
   output logic             running,
   output logic             clk_out,
   output logic             clk_rise
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] div_n;
   logic [CNT_W-1:0] pend, pend_n;
   logic             busy_n, ack_n, err_n;
   logic             clk_n, rise_n, run_n;
   logic             tog, fall;
   logic             req_ok, req_zero;

   assign tog      = (cnt == cur_div - CNT_W'(1));
   assign req_zero = cfg_req & ~cfg_busy & (cfg_div == '0);
   assign req_ok   = cfg_req & ~cfg_busy & (cfg_div != '0);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = cur_div;
      pend_n  = pend;
      busy_n  = cfg_busy;
      ack_n   = 1'b0;
      err_n   = 1'b0;
      clk_n   = clk_out;
      fall    = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            clk_n = 1'b0;
            if (run)
               state_n = RUN;
         end
         RUN: begin
            if (tog) begin
               cnt_n = '0;
               clk_n = ~clk_out;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
            fall = tog & clk_out;
            if (!run) begin
               if (!clk_out) begin
                  // already low: stop here, never start a new high phase
                  state_n = IDLE;
                  cnt_n   = '0;
                  clk_n   = 1'b0;
               end else if (tog) begin
                  // high phase ends on this very edge
                  state_n = IDLE;
               end else begin
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            if (tog) begin
               cnt_n   = '0;
               clk_n   = 1'b0;
               fall    = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            clk_n   = 1'b0;
         end
      endcase

      // A pending ratio is applied on a falling toggle, or at once
      // if the divider has meanwhile fallen back to IDLE.
      if (cfg_busy && (fall || state == IDLE)) begin
         div_n  = pend;
         cnt_n  = '0;
         busy_n = 1'b0;
         ack_n  = 1'b1;
      end else if (req_zero) begin
         ack_n = 1'b1;
         err_n = 1'b1;
      end else if (req_ok) begin
         if (state == IDLE) begin
            div_n = cfg_div;
            ack_n = 1'b1;
         end else begin
            pend_n = cfg_div;
            busy_n = 1'b1;
         end
      end

      rise_n = clk_n & ~clk_out;
      run_n  = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cur_div  <= CNT_W'(DEF_DIV);
         pend     <= '0;
         cfg_busy <= 1'b0;
         cfg_ack  <= 1'b0;
         cfg_err  <= 1'b0;
         clk_out  <= 1'b0;
         clk_rise <= 1'b0;
         running  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cur_div  <= div_n;
         pend     <= pend_n;
         cfg_busy <= busy_n;
         cfg_ack  <= ack_n;
         cfg_err  <= err_n;
         clk_out  <= clk_n;
         clk_rise <= rise_n;
         running  <= run_n;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl.
// Samples on negedge, drives inputs on negedge.
module tb_clk_div_ctrl;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       run     = 1'b0;
   logic       cfg_req = 1'b0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ack, cfg_err, cfg_busy;
   logic [7:0] cur_div;
   logic       running, clk_out, clk_rise;

   int checks = 0;
   int errors = 0;
   int hi, lo, n;

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .CNT_W  (8),
      .DEF_DIV(1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .cfg_req (cfg_req),
      .cfg_div (cfg_div),
      .cfg_ack (cfg_ack),
      .cfg_err (cfg_err),
      .cfg_busy(cfg_busy),
      .cur_div (cur_div),
      .running (running),
      .clk_out (clk_out),
      .clk_rise(clk_rise)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // negedges until clk_out equals lvl (bounded)
   task automatic wait_out(input logic lvl, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (clk_out !== lvl && cyc < 64);
   endtask

   // starts on a rise negedge; ends on the next rise negedge
   task automatic measure(output int h, output int l);
      h = 1;
      while (clk_out === 1'b1 && h < 64) begin
         @(negedge clk);
         if (clk_out === 1'b1) h++;
      end
      l = 1;
      while (clk_out === 1'b0 && l < 64) begin
         @(negedge clk);
         if (clk_out === 1'b0) l++;
      end
   endtask

   task automatic go_idle();
      int c;
      run = 1'b0;
      c   = 0;
      do begin
         @(negedge clk);
         c++;
      end while (running !== 1'b0 && c < 64);
      chk("idle_reached", running, 0);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_cur_div", cur_div, 1);
      chk("rst_running", running, 0);
      chk("rst_ack", cfg_ack, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_rise", clk_rise, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_low", clk_out, 0);

      // div=1: clk/2, first rise one cycle after run sampled
      run = 1'b1;
      @(negedge clk);
      chk("d1_running", running, 1);
      chk("d1_out0", clk_out, 0);
      @(negedge clk);
      chk("d1_out1", clk_out, 1);
      chk("d1_rise1", clk_rise, 1);
      @(negedge clk);
      chk("d1_out2", clk_out, 0);
      chk("d1_rise2", clk_rise, 0);
      @(negedge clk);
      chk("d1_out3", clk_out, 1);
      chk("d1_rise3", clk_rise, 1);
      run = 1'b0;
      @(negedge clk);
      chk("d1_stop_run", running, 0);
      chk("d1_stop_out", clk_out, 0);

      // IDLE reconfig to 2
      cfg_req = 1'b1;
      cfg_div = 8'd2;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("i2_ack", cfg_ack, 1);
      chk("i2_err", cfg_err, 0);
      chk("i2_div", cur_div, 2);
      chk("i2_busy", cfg_busy, 0);
      @(negedge clk);
      chk("i2_ack_off", cfg_ack, 0);
      run = 1'b1;
      wait_out(1'b1, n);
      chk("d2_latency", n, 3);
      measure(hi, lo);
      chk("d2_hi", hi, 2);
      chk("d2_lo", lo, 2);
      go_idle();

      // IDLE reconfig to 4
      cfg_req = 1'b1;
      cfg_div = 8'd4;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("i4_ack", cfg_ack, 1);
      chk("i4_div", cur_div, 4);
      run = 1'b1;
      wait_out(1'b1, n);
      chk("d4_latency", n, 5);
      measure(hi, lo);
      chk("d4_hi", hi, 4);
      chk("d4_lo", lo, 4);

      // change 4->2 requested in high phase
      cfg_req = 1'b1;
      cfg_div = 8'd2;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("r2_busy", cfg_busy, 1);
      chk("r2_still_hi", clk_out, 1);
      chk("r2_div_old", cur_div, 4);
      hi = 2;
      while (clk_out === 1'b1 && hi < 64) begin
         @(negedge clk);
         if (clk_out === 1'b1) hi++;
      end
      chk("r2_hi", hi, 4);
      chk("r2_ack", cfg_ack, 1);
      chk("r2_div_new", cur_div, 2);
      chk("r2_busy_off", cfg_busy, 0);
      lo = 1;
      @(negedge clk);
      chk("r2_ack_off", cfg_ack, 0);
      if (clk_out === 1'b0) lo++;
      while (clk_out === 1'b0 && lo < 64) begin
         @(negedge clk);
         if (clk_out === 1'b0) lo++;
      end
      chk("r2_lo", lo, 2);

      // change to 3, then drop run in high phase
      cfg_req = 1'b1;
      cfg_div = 8'd3;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("r3_busy", cfg_busy, 1);
      wait_out(1'b0, n);
      chk("r3_ack", cfg_ack, 1);
      chk("r3_div", cur_div, 3);
      wait_out(1'b1, n);
      chk("r3_lo", n, 3);
      run = 1'b0;
      wait_out(1'b0, n);
      chk("s3_hi", n, 3);
      chk("s3_running", running, 0);
      chk("s3_out", clk_out, 0);
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (clk_rise === 1'b1) n++;
      end
      chk("s3_no_rise", n, 0);

      // zero reject, then request ignored while busy
      run = 1'b1;
      @(negedge clk);
      chk("z_running", running, 1);
      cfg_req = 1'b1;
      cfg_div = 8'd0;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("z_ack", cfg_ack, 1);
      chk("z_err", cfg_err, 1);
      chk("z_div", cur_div, 3);
      chk("z_busy", cfg_busy, 0);
      @(negedge clk);
      chk("z_ack_off", cfg_ack, 0);
      chk("z_err_off", cfg_err, 0);
      cfg_req = 1'b1;
      cfg_div = 8'd5;
      @(negedge clk);
      chk("b_busy", cfg_busy, 1);
      chk("b_rise", clk_out, 1);
      cfg_div = 8'd7;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("b_ign_ack", cfg_ack, 0);
      chk("b_ign_busy", cfg_busy, 1);
      @(negedge clk);
      chk("b_wait_ack", cfg_ack, 0);
      chk("b_wait_hi", clk_out, 1);
      @(negedge clk);
      chk("b_fall_out", clk_out, 0);
      chk("b_apply_ack", cfg_ack, 1);
      chk("b_apply_div", cur_div, 5);
      chk("b_apply_busy", cfg_busy, 0);
      @(negedge clk);
      chk("b_ack_off", cfg_ack, 0);
      chk("b_div_kept", cur_div, 5);

      // reset mid-high phase with request pending
      wait_out(1'b1, n);
      chk("x_lo5", n, 4);
      cfg_req = 1'b1;
      cfg_div = 8'd2;
      @(negedge clk);
      cfg_req = 1'b0;
      chk("x_busy", cfg_busy, 1);
      chk("x_hi", clk_out, 1);
      #2 rst = 1'b1;
      #1;
      chk("x_async_out", clk_out, 0);
      chk("x_div", cur_div, 1);
      chk("x_busy_off", cfg_busy, 0);
      chk("x_running", running, 0);
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (cfg_ack === 1'b1) n++;
      end
      chk("x_no_ack", n, 0);
      chk("x_div_after", cur_div, 1);
      chk("x_out_after", clk_out, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
